// File: rtl/alloc_pool.sv
// alloc_pool: fixed heap of 2^ADDR_SZ cells with a LIFO free list, 2-cycle ready/valid ops.
// Optional statistics outputs (o_peak, o_nalloc) are enabled by defining ALLOC_POOL_STATS_EN.
module alloc_pool #(
  parameter int                 DATA_SZ = 16,
  parameter int                 ADDR_SZ = 4,
  parameter logic [DATA_SZ-1:0] BASE    = 16'h5000,
  parameter logic [DATA_SZ-1:0] UNDEF   = 16'h0000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_alloc,
  input  logic [DATA_SZ-1:0] i_data,
  output logic [DATA_SZ-1:0] o_addr,
  input  logic               i_free,
  input  logic [DATA_SZ-1:0] i_addr,
  input  logic               i_rd,
  input  logic               i_wr,
  output logic [DATA_SZ-1:0] o_data,
  output logic               o_ready,
  output logic               o_valid,
  output logic               o_err,
  output logic [2:0]         o_err_code,
  output logic [ADDR_SZ-1:0] o_count
`ifdef ALLOC_POOL_STATS_EN
  ,
  output logic [ADDR_SZ-1:0] o_peak,
  output logic [DATA_SZ-1:0] o_nalloc
`endif
);

  localparam int NCELL = 1 << ADDR_SZ;
  localparam logic [ADDR_SZ:0]   TOP_FULL = {1'b1, {ADDR_SZ{1'b0}}};
  localparam logic [ADDR_SZ:0]   ONE_T    = {{ADDR_SZ{1'b0}}, 1'b1};
  localparam logic [ADDR_SZ-1:0] ONE_C    = {{(ADDR_SZ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t               state_q, state_d;
  logic                 req_alloc_q, req_alloc_d, req_free_q, req_free_d;
  logic                 req_rd_q, req_rd_d, req_wr_q, req_wr_d;
  logic [DATA_SZ-1:0]   req_data_q, req_data_d, req_addr_q, req_addr_d;
  logic [DATA_SZ-1:0]   rdata_q, rdata_d, head_q, head_d;
  logic [ADDR_SZ:0]     top_q, top_d;
  logic [NCELL-1:0]     used_q, used_d;
  logic [ADDR_SZ-1:0]   count_q, count_d;
  logic [DATA_SZ-1:0]   addr_q, addr_d, data_q, data_d;
  logic                 valid_q, valid_d, err_q, err_d;
  logic [2:0]           err_code_q, err_code_d;

  logic [DATA_SZ-1:0]   mem_q [NCELL];
  logic                 mem_we;
  logic [ADDR_SZ-1:0]   mem_wa;
  logic [DATA_SZ-1:0]   mem_wd;

  logic                 accept, head_empty, need_addr, alloc_only, illegal;
  logic                 addr_bad, addr_unused;
  logic [ADDR_SZ-1:0]   req_off, rd_off;
  logic [2:0]           err_now;

  assign accept     = (state_q == S_IDLE) && (i_alloc || i_free || i_rd || i_wr);
  assign req_off    = req_addr_q[ADDR_SZ-1:0];
  assign head_empty = (head_q == UNDEF);
  assign need_addr  = req_free_q || req_rd_q || req_wr_q;
  assign alloc_only = req_alloc_q && !req_free_q;
  assign illegal    = (req_rd_q && (req_alloc_q || req_free_q || req_wr_q)) ||
                      (req_wr_q && (req_alloc_q || req_free_q));
  assign addr_bad   = (req_addr_q[DATA_SZ-1:ADDR_SZ] != BASE[DATA_SZ-1:ADDR_SZ]) ||
                      (req_off == '0) || ({1'b0, req_off} >= top_q);
  assign addr_unused = !used_q[req_off];
  // A plain alloc reads the head cell to find the next free link.
  assign rd_off     = alloc_only ? head_q[ADDR_SZ-1:0] : req_off;

  always_comb begin
    err_now = 3'd0;
    if (illegal)                                          err_now = 3'd4;
    else if (need_addr && addr_bad)                       err_now = 3'd2;
    else if (need_addr && addr_unused)                    err_now = 3'd3;
    else if (alloc_only && head_empty && top_q == TOP_FULL) err_now = 3'd1;
  end

  always_comb begin
    state_d     = state_q;
    req_alloc_d = req_alloc_q;
    req_free_d  = req_free_q;
    req_rd_d    = req_rd_q;
    req_wr_d    = req_wr_q;
    req_data_d  = req_data_q;
    req_addr_d  = req_addr_q;
    rdata_d     = rdata_q;
    head_d      = head_q;
    top_d       = top_q;
    used_d      = used_q;
    count_d     = count_q;
    addr_d      = addr_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    err_d       = err_q;
    err_code_d  = err_code_q;
    mem_we      = 1'b0;
    mem_wa      = req_off;
    mem_wd      = req_data_q;
    case (state_q)
      S_IDLE: if (accept) begin
        req_alloc_d = i_alloc;
        req_free_d  = i_free;
        req_rd_d    = i_rd;
        req_wr_d    = i_wr;
        req_data_d  = i_data;
        req_addr_d  = i_addr;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        rdata_d = mem_q[rd_off];
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        valid_d = 1'b1;
        addr_d  = UNDEF;
        data_d  = UNDEF;
        if (err_now != 3'd0) begin
          err_d = 1'b1;
          if (!err_q) err_code_d = err_now;
        end else if (req_alloc_q && req_free_q) begin
          addr_d = req_addr_q;
          mem_we = 1'b1;
        end else if (req_alloc_q) begin
          mem_we  = 1'b1;
          count_d = count_q + ONE_C;
          if (!head_empty) begin
            addr_d = head_q;
            head_d = rdata_q;
            mem_wa = head_q[ADDR_SZ-1:0];
          end else begin
            addr_d = BASE + DATA_SZ'(top_q);
            mem_wa = top_q[ADDR_SZ-1:0];
            top_d  = top_q + ONE_T;
          end
          used_d[mem_wa] = 1'b1;
        end else if (req_free_q) begin
          mem_we          = 1'b1;
          mem_wd          = head_q;
          head_d          = req_addr_q;
          used_d[req_off] = 1'b0;
          count_d         = count_q - ONE_C;
        end else if (req_rd_q) begin
          data_d = rdata_q;
        end else if (req_wr_q) begin
          mem_we = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      req_alloc_q <= 1'b0;
      req_free_q  <= 1'b0;
      req_rd_q    <= 1'b0;
      req_wr_q    <= 1'b0;
      req_data_q  <= UNDEF;
      req_addr_q  <= UNDEF;
      rdata_q     <= UNDEF;
      head_q      <= UNDEF;
      top_q       <= ONE_T;
      used_q      <= '0;
      count_q     <= '0;
      addr_q      <= UNDEF;
      data_q      <= UNDEF;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      req_alloc_q <= req_alloc_d;
      req_free_q  <= req_free_d;
      req_rd_q    <= req_rd_d;
      req_wr_q    <= req_wr_d;
      req_data_q  <= req_data_d;
      req_addr_q  <= req_addr_d;
      rdata_q     <= rdata_d;
      head_q      <= head_d;
      top_q       <= top_d;
      used_q      <= used_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Cell storage is not reset; the free list and used bitmap define validity.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_rst) mem_q[mem_wa] <= mem_wd;
  end

  assign o_addr     = addr_q;
  assign o_data     = data_q;
  assign o_ready    = (state_q == S_IDLE);
  assign o_valid    = valid_q;
  assign o_err      = err_q;
  assign o_err_code = err_code_q;
  assign o_count    = count_q;

`ifdef ALLOC_POOL_STATS_EN
  localparam logic [DATA_SZ-1:0] ONE_N = {{(DATA_SZ-1){1'b0}}, 1'b1};
  logic [ADDR_SZ-1:0] peak_q, peak_d;
  logic [DATA_SZ-1:0] nalloc_q, nalloc_d;
  logic               alloc_ok;

  assign alloc_ok = (state_q == S_DONE) && (err_now == 3'd0) && alloc_only;

  always_comb begin
    peak_d   = (count_d > peak_q) ? count_d : peak_q;
    nalloc_d = alloc_ok ? nalloc_q + ONE_N : nalloc_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      peak_q   <= '0;
      nalloc_q <= '0;
    end else begin
      peak_q   <= peak_d;
      nalloc_q <= nalloc_d;
    end
  end

  assign o_peak   = peak_q;
  assign o_nalloc = nalloc_q;
`endif

endmodule

// File: tb/tb_alloc_pool.sv
// Directed bench for alloc_pool (ADDR_SZ=4, BASE=16'h5000), default build.
module tb_alloc_pool;
  logic        i_clk = 1'b0;
  logic        i_rst, i_alloc, i_free, i_rd, i_wr;
  logic [15:0] i_data, i_addr;
  logic [15:0] o_addr, o_data;
  logic        o_ready, o_valid, o_err;
  logic [2:0]  o_err_code;
  logic [3:0]  o_count;
  int          nvec = 0;
  int          nerr = 0;

  always #5 i_clk = ~i_clk;

  alloc_pool #(.DATA_SZ(16), .ADDR_SZ(4), .BASE(16'h5000), .UNDEF(16'h0000)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_alloc(i_alloc), .i_data(i_data), .o_addr(o_addr),
    .i_free(i_free), .i_addr(i_addr), .i_rd(i_rd), .i_wr(i_wr), .o_data(o_data),
    .o_ready(o_ready), .o_valid(o_valid), .o_err(o_err), .o_err_code(o_err_code),
    .o_count(o_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // Drive one request at a negedge; returns at the negedge after the completion edge.
  task automatic op(input logic a, input logic f, input logic r, input logic w,
                    input logic [15:0] d, input logic [15:0] ad, input string tag);
    i_alloc = a; i_free = f; i_rd = r; i_wr = w; i_data = d; i_addr = ad;
    @(negedge i_clk);
    i_alloc = 1'b0; i_free = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
    chk({tag, ".busy1"}, o_ready, 1'b0);
    @(negedge i_clk);
    chk({tag, ".busy2"}, {o_ready, o_valid}, 2'b00);
    @(negedge i_clk);
    chk({tag, ".done"}, {o_ready, o_valid}, 2'b11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b0; i_alloc = 1'b0; i_free = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
    i_data = 16'h0; i_addr = 16'h0;

    // Reset state and first alloc/read/write
    do_reset();
    chk("rst.ready_valid", {o_ready, o_valid}, 2'b10);
    chk("rst.err", {o_err, o_err_code}, 4'h0);
    chk("rst.addr_data", {o_addr, o_data}, 32'h0);
    chk("rst.count", o_count, 4'd0);
    op(1, 0, 0, 0, 16'h00AA, 16'h0, "a1");
    chk("a1.addr", o_addr, 16'h5001);
    chk("a1.count", o_count, 4'd1);
    op(0, 0, 1, 0, 16'h0, 16'h5001, "r1");
    chk("r1.data", o_data, 16'h00AA);
    op(0, 0, 0, 1, 16'hBEEF, 16'h5001, "w1");
    op(0, 0, 1, 0, 16'h0, 16'h5001, "r2");
    chk("r2.data", o_data, 16'hBEEF);
    chk("r2.noerr", o_err, 1'b0);

    // Exhaust the pool
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      op(1, 0, 0, 0, 16'(i), 16'h0, "fill");
      chk("fill.addr", o_addr, 16'h5000 + 16'(i));
    end
    op(1, 0, 0, 0, 16'h0077, 16'h0, "oom");
    chk("oom.addr", o_addr, 16'h0000);
    chk("oom.err", {o_err, o_err_code}, {1'b1, 3'd1});
    chk("oom.count", o_count, 4'd15);

    // LIFO reuse
    do_reset();
    op(1, 0, 0, 0, 16'h0011, 16'h0, "l1");
    chk("l1.addr", o_addr, 16'h5001);
    op(1, 0, 0, 0, 16'h0022, 16'h0, "l2");
    chk("l2.addr", o_addr, 16'h5002);
    op(1, 0, 0, 0, 16'h0033, 16'h0, "l3");
    chk("l3.addr", o_addr, 16'h5003);
    op(0, 1, 0, 0, 16'h0, 16'h5002, "f2");
    op(0, 1, 0, 0, 16'h0, 16'h5001, "f1");
    chk("f1.count", o_count, 4'd1);
    op(1, 0, 0, 0, 16'h0044, 16'h0, "l4");
    chk("l4.addr", o_addr, 16'h5001);
    op(1, 0, 0, 0, 16'h0055, 16'h0, "l5");
    chk("l5.addr", o_addr, 16'h5002);
    chk("l5.count", o_count, 4'd3);
    chk("l5.noerr", o_err, 1'b0);

    // Double free, then bad address keeps first code
    op(0, 1, 0, 0, 16'h0, 16'h5002, "df1");
    chk("df1.count", o_count, 4'd2);
    op(0, 1, 0, 0, 16'h0, 16'h5002, "df2");
    chk("df2.err", {o_err, o_err_code}, {1'b1, 3'd3});
    chk("df2.count", o_count, 4'd2);
    op(0, 0, 1, 0, 16'h0, 16'h5000, "rbad");
    chk("rbad.err", {o_err, o_err_code}, {1'b1, 3'd3});
    chk("rbad.data", o_data, 16'h0000);

    // Alloc+free reuse
    op(1, 1, 0, 0, 16'h1234, 16'h5003, "af");
    chk("af.addr", o_addr, 16'h5003);
    chk("af.count", o_count, 4'd2);
    op(0, 0, 1, 0, 16'h0, 16'h5003, "r3");
    chk("r3.data", o_data, 16'h1234);
    op(1, 0, 0, 0, 16'h0066, 16'h0, "l6");
    chk("l6.addr", o_addr, 16'h5002);
    chk("l6.count", o_count, 4'd3);

    // Bad tag gives code 2; rd+wr gives code 4
    do_reset();
    op(0, 0, 1, 0, 16'h0, 16'h6001, "tag");
    chk("tag.err", {o_err, o_err_code}, {1'b1, 3'd2});
    do_reset();
    op(0, 0, 1, 1, 16'h0, 16'h5001, "rw");
    chk("rw.err", {o_err, o_err_code}, {1'b1, 3'd4});
    chk("rw.addr", o_addr, 16'h0000);

    // Reset while an alloc is in EXEC
    do_reset();
    op(1, 0, 0, 0, 16'h0001, 16'h0, "p1");
    op(1, 0, 0, 0, 16'h0002, 16'h0, "p2");
    chk("p2.addr", o_addr, 16'h5002);
    i_alloc = 1'b1; i_data = 16'h0003;
    @(negedge i_clk);
    i_alloc = 1'b0; i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("mid.ready_valid", {o_ready, o_valid}, 2'b10);
    chk("mid.count", o_count, 4'd0);
    @(negedge i_clk);
    chk("mid.novalid", o_valid, 1'b0);
    op(1, 0, 0, 0, 16'h0004, 16'h0, "p3");
    chk("p3.addr", o_addr, 16'h5001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/alloc_pool.md
Name: alloc_pool

Overview:
- Parametrised successor to the single-pool cell allocator: a fixed-size heap of 2^ADDR_SZ cells, each DATA_SZ bits wide.
- Serves four operations:
  - alloc: pop a cell and initialise it with data.
  - free: push a cell back.
  - rd / wr: access an allocated cell.
- Adds a ready/valid handshake, sticky error codes, double-free detection and an occupancy count.
- Sits between the sequencer/test-bench drivers and any block that needs dynamically allocated cells; addresses carry a BASE tag in the upper bits.

Parameters:
- DATA_SZ, 16: cell width and address width in bits.
- ADDR_SZ, 4: log2 of cell count; must be less than DATA_SZ.
- BASE, 16'h5000: address tag. Valid addresses are BASE+1 .. BASE+2^ADDR_SZ-1; the low ADDR_SZ bits of BASE must be 0.
- UNDEF, 16'h0000: null address/value.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_alloc  in  1  allocation request strobe
- i_data  in  DATA_SZ  initial value (alloc) or write value (wr)
- o_addr  out  DATA_SZ  allocated address, valid with o_valid
- i_free  in  1  free request strobe
- i_addr  in  DATA_SZ  target address for free/rd/wr
- i_rd  in  1  read request strobe
- i_wr  in  1  write request strobe
- o_data  out  DATA_SZ  read data, valid with o_valid
- o_ready  out  1  high when a request can be accepted
- o_valid  out  1  one-cycle completion pulse
- o_err  out  1  sticky error flag
- o_err_code  out  3  first error code: 0 none, 1 out-of-memory, 2 bad address, 3 cell not allocated / double free, 4 illegal strobe combination
- o_count  out  ADDR_SZ  number of cells currently allocated

Behaviour:
- Reset (i_rst=1 at a clock edge, including mid-operation):
  - Outputs: o_addr=UNDEF, o_data=UNDEF, o_ready=1, o_valid=0, o_err=0, o_err_code=0, o_count=0.
  - State: free-list head=UNDEF, top=1, used bitmap cleared.
  - Any in-flight operation is abandoned with no o_valid. Memory contents are don't-care.
- Request acceptance:
  - Strobes are sampled only when o_ready=1 and are ignored otherwise.
  - An accepted request drops o_ready for exactly 2 cycles.
  - o_valid pulses on the 2nd cycle after acceptance, and o_ready returns high in that same cycle.
  - Fixed latency: 2 cycles for every operation, including errors.
- FSM: IDLE -> EXEC (memory read / index select) -> DONE (write-back, o_valid) -> IDLE.
- Free list:
  - LIFO linked through cell memory; a free cell holds the full next address, and UNDEF terminates the list.
  - top = next never-used offset.
- alloc alone:
  - If head != UNDEF: o_addr=head, head<=mem[head], mem[head]<=i_data.
  - Else if top <= 2^ADDR_SZ-1: o_addr=BASE+top, mem[top]<=i_data, top++.
  - Else: error 1, o_addr=UNDEF, no state change.
  - On success: used bit set, o_count+1.
- free alone:
  - Address valid and used: mem[off]<=head, head<=i_addr, used bit cleared, o_count-1.
- alloc+free in the same cycle:
  - Cell reuse: o_addr=i_addr, mem[off]<=i_data.
  - Free list, count and used bit unchanged.
  - i_addr is validated as for free.
- rd: o_data=mem[off].
- wr: mem[off]<=i_data.
- Address validation (free/rd/wr):
  - Upper DATA_SZ-ADDR_SZ bits != BASE's upper bits, offset 0, or offset >= top -> error 2.
  - Offset in range but used bit clear -> error 3.
- Illegal strobe combinations: rd or wr together with any other strobe -> error 4.
- Any error:
  - No memory or list change.
  - o_valid still pulses; o_addr and o_data are set to UNDEF.
  - o_err sets and stays set until reset; o_err_code latches the first error only.
- o_count saturates only by construction; the maximum is 2^ADDR_SZ-1.

Optional Feature:
- Macro: ALLOC_POOL_STATS_EN.
- Defined:
  - Adds output o_peak [ADDR_SZ], the high-water mark of o_count since reset (reset value 0).
  - Adds output o_nalloc [DATA_SZ], the count of successful allocs. It wraps modulo 2^DATA_SZ; alloc+free reuse is not counted.
- Undefined: neither port nor its registers exist; all other behaviour is identical.

Test Plan (ADDR_SZ=4, BASE=16'h5000):
- Reset, then alloc with i_data=16'h00AA -> o_valid 2 cycles later, o_addr=16'h5001, o_count=1; rd 16'h5001 -> o_data=16'h00AA.
- 15 allocs -> addresses 5001..500F; 16th alloc -> o_addr=UNDEF, o_err=1, o_err_code=1, o_count=15.
- Alloc 5001, 5002, 5003; free 5002; free 5001; alloc twice -> 5001 then 5002 (LIFO); o_count=3.
- Free 5002 twice -> second free: o_err_code=3; rd 5000 -> still 3 (first error kept), no state change.
- Alloc+free(5003) with i_data=16'h1234 -> o_addr=5003, o_count unchanged; rd 5003 -> 16'h1234; rd+wr together -> o_err_code=4 on a fresh reset.
- Assert i_rst during EXEC of an alloc -> no o_valid, o_ready=1 next cycle, next alloc returns 5001.
